// File: rtl/hack_seq_pkg.sv
// hack_seq_pkg: shared states, jump codes and instruction field positions for the Hack sequencer
package hack_seq_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEMRD, EXEC, MEMWR, ERROR} state_t;
    localparam logic [2:0] J_NULL = 3'b000;
    localparam logic [2:0] J_GT   = 3'b001;
    localparam logic [2:0] J_EQ   = 3'b010;
    localparam logic [2:0] J_GE   = 3'b011;
    localparam logic [2:0] J_LT   = 3'b100;
    localparam logic [2:0] J_NE   = 3'b101;
    localparam logic [2:0] J_LE   = 3'b110;
    localparam logic [2:0] J_MP   = 3'b111;
    localparam int CTYPE = 15;
    localparam int ABIT  = 12;
    localparam int DA    = 5;
    localparam int DD    = 4;
    localparam int DM    = 3;
endpackage

// File: rtl/hack_cpu_sequencer_jump.sv
// hack_jump_eval: Hack jump condition from jump code and ALU zero/negative flags
module hack_jump_eval
    import hack_seq_pkg::*;
(
    input  logic [2:0] jcode,
    input  logic       zy,
    input  logic       cy,
    output logic       take
);
    always_comb
        case (jcode)
            J_GT:    take = !cy && !zy;
            J_EQ:    take = zy;
            J_GE:    take = !cy;
            J_LT:    take = cy && !zy;
            J_NE:    take = !zy;
            J_LE:    take = cy || zy;
            J_MP:    take = 1'b1;
            default: take = 1'b0;
        endcase
endmodule

// File: rtl/hack_cpu_sequencer.sv
// hack_cpu_sequencer: multi-cycle Hack control FSM with ROM/RAM handshakes and commit strobes
module hack_cpu_sequencer
    import hack_seq_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [15:0]      instr,
    output logic             rom_req,
    input  logic             rom_ack,
    output logic             ram_rd_req,
    output logic             ram_wr_req,
    input  logic             ram_ack,
    input  logic             zy,
    input  logic             cy,
    output logic             ir_we,
    output logic             m_we,
    output logic             a_sel,
    output logic             a_we,
    output logic             d_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = $clog2(WAIT_LIMIT + 1);
    state_t        state, state_n;
    logic [15:0]   ir;
    logic [WW-1:0] wcnt;
    logic          take, take_q, jump, commit, timeout;
    logic          unused_ir;
    hack_jump_eval u_jump (.jcode(ir[2:0]), .zy(zy), .cy(cy), .take(take));
    // flags are only valid in EXEC, so a write-back commit uses the decision latched there
    assign jump      = (state == EXEC) ? take : take_q;
    assign timeout   = wcnt == WW'(WAIT_LIMIT - 1);
    assign a_sel     = ir[ABIT];
    assign busy      = state != IDLE && state != ERROR;
    assign err       = state == ERROR;
    assign unused_ir = ^{ir[14:13], ir[11:6]};
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= IDLE;
            ir      <= '0;
            wcnt    <= '0;
            take_q  <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_n;
            wcnt  <= (state_n == state) ? wcnt + WW'(1) : '0;
            if (ir_we) ir <= instr;
            if (state == EXEC) take_q <= take;
            if (pc_inc || pc_load) retired <= retired + CNT_W'(1);
        end
    always_comb begin
        state_n    = state;
        rom_req    = 1'b0;
        ram_rd_req = 1'b0;
        ram_wr_req = 1'b0;
        ir_we      = 1'b0;
        m_we       = 1'b0;
        a_we       = 1'b0;
        d_we       = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: state_n = run ? FETCH : IDLE;
            FETCH: begin
                rom_req = 1'b1;
                ir_we   = rom_ack;
                state_n = rom_ack ? DECODE : timeout ? ERROR : FETCH;
            end
            DECODE: begin
                a_we    = !ir[CTYPE];
                pc_inc  = !ir[CTYPE];
                state_n = !ir[CTYPE] ? (run ? FETCH : IDLE) : ir[ABIT] ? MEMRD : EXEC;
            end
            MEMRD: begin
                ram_rd_req = 1'b1;
                m_we       = ram_ack;
                state_n    = ram_ack ? EXEC : timeout ? ERROR : MEMRD;
            end
            EXEC: begin
                commit  = !ir[DM];
                state_n = ir[DM] ? MEMWR : EXEC;
            end
            MEMWR: begin
                ram_wr_req = 1'b1;
                commit     = ram_ack;
                state_n    = timeout ? ERROR : MEMWR;
            end
            default: ;
        endcase
        // commit overrides the timeout path, so an ack on the limit cycle still wins
        if (commit) begin
            a_we    = ir[DA];
            d_we    = ir[DD];
            pc_load = jump;
            pc_inc  = !jump;
            state_n = run ? FETCH : IDLE;
        end
    end
endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// tb_hack_cpu_sequencer: randomized scoreboard bench with instruction-level reference model
`timescale 1ns/1ps
module tb_hack_cpu_sequencer;
    logic        clk = 1'b0, rst = 1'b0, run = 1'b0;
    logic [15:0] instr = '0;
    logic        rom_ack = 1'b0, ram_ack = 1'b0, zy = 1'b0, cy = 1'b0;
    logic        rom_req, ram_rd_req, ram_wr_req, ir_we, m_we, a_sel, a_we, d_we;
    logic        pc_inc, pc_load, busy, err;
    logic [15:0] retired;

    hack_cpu_sequencer #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .rom_req(rom_req), .rom_ack(rom_ack),
        .ram_rd_req(ram_rd_req), .ram_wr_req(ram_wr_req), .ram_ack(ram_ack), .zy(zy), .cy(cy),
        .ir_we(ir_we), .m_we(m_we), .a_sel(a_sel), .a_we(a_we), .d_we(d_we), .pc_inc(pc_inc),
        .pc_load(pc_load), .busy(busy), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        int          rw;
        int          mw;
        logic        z;
        logic        c;
    } item_t;

    item_t       prog[$];
    item_t       exp_q[$];
    int          vecs = 0, errs = 0;
    logic [15:0] n_commit = '0;
    bit          run_ovr = 1'b0, run_val = 1'b0;
    int          cur_mw = 0, rcnt = 0, mcnt = 0;
    int          lat = 0, rom_c = 0, rd_c = 0, wr_c = 0, mwe_c = 0, irwe_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic jtab(input logic [2:0] j, input logic z, input logic c);
        case (j)
            3'd1:    return !c && !z;
            3'd2:    return z;
            3'd3:    return !c;
            3'd4:    return c && !z;
            3'd5:    return !z;
            3'd6:    return c || z;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic [15:0] ins, input int rw, input int mw, input logic z, input logic c);
        item_t it;
        it.ins = ins; it.rw = rw; it.mw = mw; it.z = z; it.c = c;
        prog.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #7;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((prog.size() != 0 || exp_q.size() != 0 || busy) && n < lim) begin
            step();
            n++;
        end
        chk("drain_done", 32'(n < lim), 1);
    endtask

    // memory responders: ROM serves the program queue with per-instruction wait states
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            rom_ack = 1'b0; ram_ack = 1'b0; rcnt = 0; mcnt = 0;
        end else begin
            rom_ack = 1'b0;
            instr = 16'($urandom);
            if (rom_req && prog.size() != 0) begin
                if (rcnt == prog[0].rw) begin
                    rom_ack = 1'b1;
                    instr = prog[0].ins;
                    zy = prog[0].z;
                    cy = prog[0].c;
                    cur_mw = prog[0].mw;
                    exp_q.push_back(prog.pop_front());
                    rcnt = 0;
                end else rcnt++;
            end else rcnt = 0;
            ram_ack = 1'b0;
            if (ram_rd_req || ram_wr_req) begin
                if (mcnt == cur_mw) begin
                    ram_ack = 1'b1;
                    mcnt = 0;
                end else mcnt++;
            end else mcnt = 0;
        end
        run = run_ovr ? run_val : (prog.size() != 0);
    end

    // monitor: accumulates per-instruction activity and checks it at each commit
    initial forever begin
        item_t it;
        logic ct, rd, wr, tk;
        @(posedge clk);
        #9;
        if (!rst) begin
            lat = 0; rom_c = 0; rd_c = 0; wr_c = 0; mwe_c = 0; irwe_c = 0;
            n_commit = '0;
        end else begin
            lat += int'(busy); rom_c += int'(rom_req); rd_c += int'(ram_rd_req);
            wr_c += int'(ram_wr_req); mwe_c += int'(m_we); irwe_c += int'(ir_we);
            if (pc_inc || pc_load) begin
                if (exp_q.size() == 0) chk("commit_unexpected", 32'd1, 32'd0);
                else begin
                    it = exp_q.pop_front();
                    ct = it.ins[15];
                    rd = ct & it.ins[12];
                    wr = ct & it.ins[3];
                    tk = ct & jtab(it.ins[2:0], it.z, it.c);
                    chk("strobes", {a_we, d_we, pc_inc, pc_load}, {ct ? it.ins[5] : 1'b1, ct & it.ins[4], !tk, tk});
                    chk("latency", lat, it.rw + 2 + int'(ct) + (rd ? it.mw + 1 : 0) + (wr ? it.mw + 1 : 0));
                    chk("rom_req_cycles", rom_c, it.rw + 1);
                    chk("ram_rd_cycles", rd_c, rd ? it.mw + 1 : 0);
                    chk("ram_wr_cycles", wr_c, wr ? it.mw + 1 : 0);
                    chk("m_we_pulses", mwe_c, 32'(rd));
                    chk("ir_we_pulses", irwe_c, 1);
                    chk("a_sel", a_sel, it.ins[12]);
                    chk("retired", retired, n_commit);
                end
                n_commit++;
                lat = 0; rom_c = 0; rd_c = 0; wr_c = 0; mwe_c = 0; irwe_c = 0;
            end else if (a_we || d_we) chk("stray_reg_we", {a_we, d_we}, 2'b00);
        end
    end

    initial begin
        int n;
        repeat (3) step();
        chk("reset_outputs", {rom_req, ram_rd_req, ram_wr_req, ir_we, m_we, a_sel, a_we, d_we,
                              pc_inc, pc_load, busy, err}, 12'h000);
        chk("reset_retired", retired, 0);
        rst = 1'b1;
        push(16'h0005, 0, 0, 1'b0, 1'b0);
        drain(50);
        push(16'hEC10, 0, 0, 1'b0, 1'b0);
        drain(50);
        push(16'hFC08, 2, 2, 1'b0, 1'b0);
        drain(50);
        push(16'hE302, 0, 0, 1'b1, 1'b0);
        push(16'hE302, 0, 0, 1'b0, 1'b0);
        drain(50);
        for (int j = 0; j < 8; j++)
            for (int f = 0; f < 4; f++)
                push(16'hE300 | 16'(j), 0, 0, f[1], f[0]);
        drain(400);
        repeat (8) begin
            repeat (25) push(16'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom), 1'($urandom));
            drain(1000);
        end
        // sole instruction: run falls during its RAM read
        push(16'hFC10, 0, 3, 1'b0, 1'b0);
        drain(50);
        repeat (3) step();
        chk("idle_after_run_drop", {busy, rom_req}, 2'b00);
        push(16'h0007, 14, 0, 1'b0, 1'b0);
        drain(60);
        chk("ack_at_limit_no_err", err, 0);
        push(16'h0007, 15, 0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40 && !err; i++) begin
            step();
            n += int'(rom_req);
        end
        chk("timeout_err", err, 1);
        chk("timeout_req_cycles", n, 15);
        run_ovr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_val = i[0];
            step();
            chk("error_sticky", {err, busy, rom_req}, 3'b100);
        end
        rst = 1'b0;
        prog.delete();
        exp_q.delete();
        run_ovr = 1'b0;
        step();
        chk("err_cleared", err, 0);
        rst = 1'b1;
        push(16'h0009, 0, 0, 1'b0, 1'b0);
        push(16'hFC08, 0, 8, 1'b0, 1'b0);
        n = 0;
        while (!ram_wr_req && n < 60) begin
            step();
            n++;
        end
        chk("reached_memwr", ram_wr_req, 1);
        rst = 1'b0;
        #1;
        chk("reset_drops_wr", {ram_wr_req, busy}, 2'b00);
        chk("reset_retired_mid", retired, 0);
        prog.delete();
        exp_q.delete();
        step();
        rst = 1'b1;
        push(16'h0003, 1, 0, 1'b0, 1'b0);
        drain(50);
        chk("retired_after_reset", retired, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
